// File: rtl/hkspi_slave_ctrl.sv
// Housekeeping SPI slave (mode 0): turns a command / address / data byte stream
// into single-cycle register read and write strobes on the system clock.
module hkspi_slave_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       resetb,
    input  logic       sck,
    input  logic       csb,
    input  logic       sdi,
    output logic       sdo,
    output logic       sdo_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    // Fewer than two stages cannot resolve metastability, so clamp.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        IDLE,
        COMMAND,
        ADDRESS,
        DATA,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [STAGES-1:0] sck_sync, csb_sync, sdi_sync;
    logic [STAGES:0]   fill;
    logic              sck_d, csb_d;
    logic              sck_s, csb_s, sdi_s, sync_ok;
    logic              sck_rise, sck_fall, csb_fall;
    logic              shifting, byte_end, last_byte;

    logic [2:0]        bit_cnt;
    logic [6:0]        shift;
    logic [7:0]        rx_byte;
    logic [1:0]        mode;
    logic [2:0]        n_bytes;
    logic [2:0]        byte_cnt;
    logic [7:0]        tx;
    logic              sdo_q;
    logic              inc_pend;

    // ---------------------------------------------------------------------
    // Pad synchronizers and edge detection
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, which is what makes the chain a shift.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sck_sync <= '0;
            csb_sync <= '1;
            sdi_sync <= '0;
            sck_d    <= 1'b0;
            csb_d    <= 1'b1;
            fill     <= '0;
        end else begin
            sck_sync <= {sck_sync[STAGES-2:0], sck};
            csb_sync <= {csb_sync[STAGES-2:0], csb};
            sdi_sync <= {sdi_sync[STAGES-2:0], sdi};
            sck_d    <= sck_sync[STAGES-1];
            csb_d    <= csb_sync[STAGES-1];
            fill     <= {fill[STAGES-1:0], 1'b1};
        end
    end

    assign sck_s = sck_sync[STAGES-1];
    assign csb_s = csb_sync[STAGES-1];
    assign sdi_s = sdi_sync[STAGES-1];

    // Edges only count once the chain holds real pad samples, so a csb held low
    // through reset never looks like a fresh select.
    assign sync_ok  = fill[STAGES];
    assign sck_rise = sync_ok && sck_s && !sck_d && !csb_s;
    assign sck_fall = sync_ok && !sck_s && sck_d && !csb_s;
    assign csb_fall = sync_ok && csb_d && !csb_s;

    assign shifting  = sck_rise && (state == COMMAND || state == ADDRESS || state == DATA);
    assign byte_end  = shifting && (bit_cnt == 3'd7);
    assign rx_byte   = {shift, sdi_s};
    assign last_byte = (n_bytes != 3'd0) && (byte_cnt == n_bytes - 3'd1);

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) state <= IDLE;
        else         state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        sdo_oe    = (state == DATA) && mode[0];
        case (state)
            IDLE:    if (csb_fall) state_nxt = COMMAND;
            COMMAND: if (byte_end) state_nxt = (rx_byte[7:6] == 2'b00) ? DONE : ADDRESS;
            ADDRESS: if (byte_end) state_nxt = DATA;
            DATA:    if (byte_end && last_byte) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE && csb_s) state_nxt = IDLE;
    end

    assign sdo = sdo_oe && sdo_q;

    // ---------------------------------------------------------------------
    // Shift registers, address counter and strobes
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            bit_cnt   <= '0;
            shift     <= '0;
            mode      <= '0;
            n_bytes   <= '0;
            byte_cnt  <= '0;
            tx        <= '0;
            sdo_q     <= 1'b0;
            inc_pend  <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;

            if (state == IDLE) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
                sdo_q    <= 1'b0;
            end

            if (shifting) begin
                shift   <= rx_byte[6:0];
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (byte_end) begin
                case (state)
                    COMMAND: begin
                        mode    <= rx_byte[7:6];
                        n_bytes <= rx_byte[5:3];
                    end
                    ADDRESS: begin
                        reg_addr <= rx_byte;
                        reg_re   <= mode[0];
                    end
                    DATA: begin
                        if (mode[1]) begin
                            reg_wdata <= rx_byte;
                            reg_we    <= 1'b1;
                        end
                        byte_cnt <= byte_cnt + 3'd1;
                        inc_pend <= 1'b1;
                    end
                    default: ;
                endcase
            end

            // The increment trails the write strobe by one cycle so the write
            // lands on the old address and the next read on the new one.
            if (inc_pend) begin
                inc_pend <= 1'b0;
                reg_addr <= reg_addr + 8'd1;
                reg_re   <= (state == DATA) && mode[0] && !csb_s;
            end

            if (reg_re) begin
                tx <= reg_rdata;
            end else if (sck_fall && state == DATA) begin
                sdo_q <= tx[7];
                tx    <= {tx[6:0], 1'b0};
            end
        end
    end

endmodule
